// File: rtl/sample_history_reader.sv
// sample_history_reader
//   Read side of the sample history buffer in the AIS frame detector.
//   Every accepted input sample goes into a circular RAM. When the detector
//   triggers, the block replays a fixed-length window on an AXIS master. The
//   window starts PAR_LOOKBACK samples before the trigger point, or at the
//   oldest sample written since reset if the history is shorter than that.
//   The demodulator can therefore decode a frame from slightly before its
//   detected start.
//
// Optional build macro: HIST_READER_TIMESTAMP_EN
//   When defined, a 32-bit free-running sample counter is added, along with
//   the output o_start_idx. That output holds the absolute sample index of
//   the first replayed beat of the most recently accepted trigger.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   s_axis_tvalid     input sample strobe (always accepted, no tready)
//   s_axis_tdata      input sample
//   i_trig            single-cycle frame-detect pulse
//   m_axis_tvalid     replay beat valid
//   m_axis_tready     downstream ready
//   m_axis_tdata      replayed sample
//   m_axis_tlast      last beat of the frame
//   m_axis_tuser      frame truncated by overrun (qualifies tlast)
//   o_busy            replay in progress
//   o_trig_drop       one-cycle pulse after a trigger was ignored
//   o_start_idx       (HIST_READER_TIMESTAMP_EN only) first replayed sample index
//
// FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for i_trig; the write side keeps filling the history
//   ST_STREAM | replaying the window; further triggers are dropped

module sample_history_reader #(
  parameter int PAR_DATA_WIDTH = 32,
  parameter int PAR_DEPTH      = 1024,
  parameter int PAR_LOOKBACK   = 256,
  parameter int PAR_FRAME_LEN  = 512
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      s_axis_tvalid,
  input  logic [PAR_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      i_trig,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [PAR_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  output logic                      o_busy,
  output logic                      o_trig_drop
`ifdef HIST_READER_TIMESTAMP_EN
  ,
  output logic [31:0]               o_start_idx
`endif
);

  localparam int AW = $clog2(PAR_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(PAR_FRAME_LEN + 1);

  localparam logic [PW-1:0] DEPTH_P    = PW'(PAR_DEPTH);
  localparam logic [PW-1:0] LOOKBACK_P = PW'(PAR_LOOKBACK);
  localparam logic [PW-1:0] OVR_LEVEL  = PW'(PAR_DEPTH - 2);
  localparam logic [BW-1:0] FRAME_P    = BW'(PAR_FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(PAR_FRAME_LEN - 1);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  state_t state_q, state_d;

  logic [PAR_DATA_WIDTH-1:0] mem [PAR_DEPTH];
  logic [PAR_DATA_WIDTH-1:0] rd_data;
  logic                      rd_vld;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] hist_cnt;
  logic [PW-1:0] avail;
  logic [PW-1:0] lookback;

  // Two-entry output stage: ent0 is the presented beat, ent1 the skid slot.
  logic [PAR_DATA_WIDTH-1:0] ent0, ent1;
  logic [1:0]                stage_cnt;
  logic [2:0]                occ_after;

  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] issue_cnt;
  logic          ovr;

  // tlast/tuser of a beat that was already presented but not yet accepted
  // are frozen. Without this, an overrun flagged during a stall could
  // change them while tvalid is held.
  logic hold_q, last_q, user_q;
  logic last_c, user_c;

  logic streaming;
  logic pop;
  logic rd_en;
  logic overrun_evt;
  logic trig_accept;
  logic frame_end;
  logic starve;
  logic trig_drop_q;

  assign streaming   = (state_q == ST_STREAM);
  assign avail       = wr_ptr - rd_ptr;
  assign lookback    = (hist_cnt < LOOKBACK_P) ? hist_cnt : LOOKBACK_P;
  assign trig_accept = (state_q == ST_IDLE) && i_trig;

  assign m_axis_tvalid = streaming && (stage_cnt != 2'd0);
  assign m_axis_tdata  = ent0;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Stage occupancy after this cycle if no read were issued: entries held
  // plus the read in flight, minus the beat leaving. A read is issued only
  // if it will have a slot when it lands.
  assign occ_after = 3'(stage_cnt) + 3'(rd_vld) - 3'(pop);

  assign rd_en = streaming && !ovr && (avail != '0) &&
                 (issue_cnt < FRAME_P) && (occ_after < 3'd2);

  assign overrun_evt = streaming && s_axis_tvalid && (avail >= OVR_LEVEL);

  // After an overrun no more reads are issued. The beat that is presented
  // once nothing stands behind it (no skid entry, no read in flight)
  // closes the frame.
  assign last_c = (beat_cnt == LAST_BEAT) ||
                  (ovr && (stage_cnt == 2'd1) && !rd_vld);
  assign user_c = ovr && last_c;

  assign m_axis_tlast = m_axis_tvalid && (hold_q ? last_q : last_c);
  assign m_axis_tuser = m_axis_tvalid && (hold_q ? user_q : user_c);

  assign frame_end = pop && m_axis_tlast;
  // Safety exit: a stage that is truncated and empty has nothing left to
  // present.
  assign starve    = streaming && ovr && (stage_cnt == 2'd0) && !rd_vld;

  assign o_busy      = streaming;
  assign o_trig_drop = trig_drop_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_trig) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (frame_end || starve) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM: one write port, one registered read port.
  always_ff @(posedge i_clk) begin
    if (s_axis_tvalid) begin
      mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end
    if (rd_en) begin
      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      hist_cnt <= '0;
    end else if (s_axis_tvalid) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (hist_cnt != DEPTH_P) begin
        hist_cnt <= hist_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr      <= '0;
      rd_vld      <= 1'b0;
      ent0        <= '0;
      ent1        <= '0;
      stage_cnt   <= 2'd0;
      beat_cnt    <= '0;
      issue_cnt   <= '0;
      ovr         <= 1'b0;
      hold_q      <= 1'b0;
      last_q      <= 1'b0;
      user_q      <= 1'b0;
      trig_drop_q <= 1'b0;
    end else begin
      rd_vld      <= rd_en;
      trig_drop_q <= streaming && i_trig;

      if (trig_accept) begin
        // The pre-write pointer is used, so a sample written in the trigger
        // cycle lands after the trigger point.
        rd_ptr    <= wr_ptr - lookback;
        beat_cnt  <= '0;
        issue_cnt <= '0;
        ovr       <= 1'b0;
        stage_cnt <= 2'd0;
        hold_q    <= 1'b0;
      end else if (streaming) begin
        if (rd_en) begin
          rd_ptr    <= rd_ptr + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (pop) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (overrun_evt) begin
          ovr <= 1'b1;
        end

        case ({rd_vld, pop})
          2'b10: begin
            if (stage_cnt == 2'd0) begin
              ent0 <= rd_data;
            end else begin
              ent1 <= rd_data;
            end
            stage_cnt <= stage_cnt + 2'd1;
          end
          2'b01: begin
            ent0      <= ent1;
            stage_cnt <= stage_cnt - 2'd1;
          end
          2'b11: begin
            if (stage_cnt == 2'd1) begin
              ent0 <= rd_data;
            end else begin
              ent0 <= ent1;
              ent1 <= rd_data;
            end
          end
          default: ;
        endcase

        hold_q <= m_axis_tvalid && !m_axis_tready;
        last_q <= m_axis_tlast;
        user_q <= m_axis_tuser;

        if (state_d == ST_IDLE) begin
          stage_cnt <= 2'd0;
          hold_q    <= 1'b0;
        end
      end
    end
  end

`ifdef HIST_READER_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ts_cnt      <= '0;
      o_start_idx <= '0;
    end else begin
      if (s_axis_tvalid) begin
        ts_cnt <= ts_cnt + 32'd1;
      end
      if (trig_accept) begin
        o_start_idx <= ts_cnt - 32'(lookback);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sample_history_reader.sv
module tb_sample_history_reader;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LB    = 4;
  localparam int FL    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          trig = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tuser;
  logic          busy;
  logic          trig_drop;
`ifdef HIST_READER_TIMESTAMP_EN
  logic [31:0]   start_idx_o;
`endif

  always #5 clk = ~clk;

  sample_history_reader #(
    .PAR_DATA_WIDTH (DW),
    .PAR_DEPTH      (DEPTH),
    .PAR_LOOKBACK   (LB),
    .PAR_FRAME_LEN  (FL)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .i_trig        (trig),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .o_busy        (busy),
    .o_trig_drop   (trig_drop)
`ifdef HIST_READER_TIMESTAMP_EN
    ,
    .o_start_idx   (start_idx_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: every sample written since reset, in order. An
  // accepted trigger fixes the window start as an index into this history.
  // Beat k of the frame must be history[start + k].
  logic [31:0] samples[$];
  bit          frame_active = 1'b0;
  int          start_idx = 0;
  int          beat_k = 0;
  bit          drop_pend = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic        prev_user = 1'b0;
  logic [31:0] frame_data[$];
  bit          frame_done = 1'b0;
  bit          frame_last_user = 1'b0;
  bit          ts_pend = 1'b0;
  int          ts_exp = 0;

  always @(negedge clk) begin
    int  idx;
    bit  busy_now;
    if (!rst_n) begin
      samples.delete();
      frame_active = 1'b0;
      drop_pend    = 1'b0;
      stall_prev   = 1'b0;
      ts_pend      = 1'b0;
    end else begin
      busy_now = frame_active;
      check("busy", 32'(busy), 32'(busy_now));
      check("trig_drop", 32'(trig_drop), 32'(drop_pend));
      if (!busy_now) check("idle_tvalid", 32'(m_tvalid), 32'd0);
`ifdef HIST_READER_TIMESTAMP_EN
      if (ts_pend) check("start_idx", start_idx_o, 32'(ts_exp));
`endif
      ts_pend = 1'b0;
      if (stall_prev) begin
        check("hold_tvalid", 32'(m_tvalid), 32'd1);
        check("hold_tdata", m_tdata, prev_data);
        check("hold_tlast", 32'(m_tlast), 32'(prev_last));
        check("hold_tuser", 32'(m_tuser), 32'(prev_user));
      end
      if (m_tvalid && m_tready && busy_now) begin
        idx = start_idx + beat_k;
        check("beat_written", 32'(idx < samples.size()), 32'd1);
        if (idx < samples.size()) check("tdata", m_tdata, samples[idx]);
        check("tuser_without_tlast", 32'(m_tuser && !m_tlast), 32'd0);
        check("tlast", 32'(m_tlast), 32'((beat_k == FL - 1) || m_tuser));
        frame_data.push_back(m_tdata);
        beat_k++;
        if (m_tlast) begin
          frame_active    = 1'b0;
          frame_done      = 1'b1;
          frame_last_user = m_tuser;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_user  = m_tuser;

      // Inputs that the coming rising edge will sample.
      drop_pend = trig && busy_now;
      if (trig && !busy_now) begin
        frame_active = 1'b1;
        start_idx    = samples.size() - ((samples.size() < LB) ? samples.size() : LB);
        beat_k       = 0;
        frame_data.delete();
        frame_done   = 1'b0;
        ts_pend      = 1'b1;
        ts_exp       = start_idx;
      end
      if (s_tvalid) samples.push_back(s_tdata);
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit t);
    s_tvalid = v;
    s_tdata  = d;
    trig     = t;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    trig     = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    for (int i = 0; i < budget && !frame_done; i++) drive(1'b0, '0, 1'b0);
    check("frame_completes", 32'(frame_done), 32'd1);
  endtask

  task automatic check_frame(input string name, input int len, input int first);
    check({name, "_len"}, 32'(frame_data.size()), 32'(len));
    for (int k = 0; k < len; k++)
      check({name, "_data"}, (k < frame_data.size()) ? frame_data[k] : 32'hFFFF_FFFF, 32'(first + k));
    check({name, "_tuser"}, 32'(frame_last_user), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trig_drop", 32'(trig_drop), 32'd0);
    rst_n = 1'b1;

    // 1: full history, trigger while sample 20 is written -> 16..23
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b1, 32'd20, 1'b1);
    for (int i = 21; i < 24; i++) drive(1'b1, 32'(i), 1'b0);
    wait_frame(60);
    check_frame("t1", 8, 16);

    // 2: short history after reset, lookback clamps to sample 0 -> 0..7
    do_reset();
    drive(1'b1, 32'd0, 1'b0);
    drive(1'b1, 32'd1, 1'b0);
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 2; i < 10; i++) drive(1'b1, 32'(i), 1'b0);
    wait_frame(60);
    check_frame("t2", 8, 0);

    // 3: random ready, writes every other cycle -> 106..113
    for (int i = 100; i < 110; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b1, 32'd110, 1'b1);
    begin
      int d = 111;
      for (int c = 0; c < 120 && !frame_done; c++) begin
        m_tready = 1'($urandom_range(0, 1));
        drive(c[0], 32'(d), 1'b0);
        if (c[0]) d++;
      end
    end
    m_tready = 1'b1;
    check("t3_done", 32'(frame_done), 32'd1);
    check_frame("t3", 8, 106);

    // 4: ready held low while writes continue -> truncated frame
    for (int i = 200; i < 210; i++) drive(1'b1, 32'(i), 1'b0);
    m_tready = 1'b0;
    drive(1'b1, 32'd210, 1'b1);
    for (int i = 211; i < 231; i++) drive(1'b1, 32'(i), 1'b0);
    m_tready = 1'b1;
    wait_frame(30);
    check("t4_short", 32'(frame_data.size() < FL), 32'd1);
    check("t4_nonempty", 32'(frame_data.size() > 0), 32'd1);
    check("t4_first", (frame_data.size() > 0) ? frame_data[0] : 32'hFFFF_FFFF, 32'd206);
    check("t4_tuser", 32'(frame_last_user), 32'd1);
    drive(1'b0, '0, 1'b0);
    check("t4_idle", 32'(busy), 32'd0);

    // 5: second trigger mid-frame is dropped, frame unaffected -> 306..313
    for (int i = 300; i < 310; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b1, 32'd310, 1'b1);
    drive(1'b1, 32'd311, 1'b0);
    drive(1'b1, 32'd312, 1'b0);
    drive(1'b1, 32'd313, 1'b1);
    check("t5_drop_pulse", 32'(trig_drop), 32'd1);
    drive(1'b1, 32'd314, 1'b0);
    check("t5_drop_clear", 32'(trig_drop), 32'd0);
    for (int i = 315; i < 321; i++) drive(1'b1, 32'(i), 1'b0);
    wait_frame(40);
    check_frame("t5", 8, 306);

    // 6: reset mid-frame, then replay only post-reset history -> 500..507
    for (int i = 400; i < 410; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b1, 32'd410, 1'b1);
    for (int i = 411; i < 414; i++) drive(1'b1, 32'(i), 1'b0);
    check("t6_midframe", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("t6_rst_tdata", m_tdata, 32'd0);
    check("t6_rst_tlast", 32'(m_tlast), 32'd0);
    check("t6_rst_tuser", 32'(m_tuser), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 500; i < 503; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b0, '0, 1'b1);
    for (int i = 503; i < 511; i++) drive(1'b1, 32'(i), 1'b0);
    wait_frame(60);
    check_frame("t6", 8, 500);

    repeat (2) drive(1'b0, '0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
